imm_encoder: RTL and testbench

- Inverse of the immediate decode path. Packs opcode, register and funct3 fields plus a 32-bit signed immediate into a 32-bit RV32I instruction word for I-load, S and B formats.
- Sits between the program-loader / self-test stimulus source and the instruction-memory write port.
- Two-stage valid/ready pipeline with immediate range checking and a running write-address counter.

---
 rtl/imm_encoder.sv | 167 ++++++++++++++++
 tb/tb_imm_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder: packs RV32I I-load/S/B fields and a signed immediate
// into an instruction word. Define IMM_ENC_IALU_EN to also accept I-type ALU (0010011).
module imm_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_err,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_seen
);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
`ifdef IMM_ENC_IALU_EN
  localparam logic [6:0]  OP_IALU   = 7'b0010011;
`endif
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  req_t              in_req;
  req_t              s1_req_q,   s1_req_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_instr_q, s2_instr_d;
  logic              s2_err_q,   s2_err_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              err_seen_q, err_seen_d;

  logic        advance, out_fire;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic [31:0] word_i, word_s, word_b;
  logic        i_range_ok, b_range_ok;

  assign in_req = '{opcode: in_opcode, rd: in_rd, funct3: in_funct3,
                    rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign out_fire = s2_valid_q && out_ready;

  // Field layouts and immediate range checks on the S1 entry.
  always_comb begin
    word_i = {s1_req_q.imm[11:0], s1_req_q.rs1, s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
    word_s = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
              s1_req_q.imm[4:0], s1_req_q.opcode};
    word_b = {s1_req_q.imm[12], s1_req_q.imm[10:5], s1_req_q.rs2, s1_req_q.rs1,
              s1_req_q.funct3, s1_req_q.imm[4:1], s1_req_q.imm[11], s1_req_q.opcode};
    i_range_ok = (&s1_req_q.imm[31:11]) || !(|s1_req_q.imm[31:11]);
    b_range_ok = ((&s1_req_q.imm[31:12]) || !(|s1_req_q.imm[31:12])) && !s1_req_q.imm[0];
  end

  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b1;
    case (s1_req_q.opcode)
      OP_LOAD: begin
        if (i_range_ok) begin
          enc_instr = word_i;
          enc_err   = 1'b0;
        end
      end
      OP_STORE: begin
        if (i_range_ok) begin
          enc_instr = word_s;
          enc_err   = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (b_range_ok) begin
          enc_instr = word_b;
          enc_err   = 1'b0;
        end
      end
`ifdef IMM_ENC_IALU_EN
      OP_IALU: begin
        // Shifts carry a 5-bit shamt; bit 10 selects SRAI and is legal only with funct3 101.
        case (s1_req_q.funct3)
          3'b001: enc_err = |s1_req_q.imm[31:5];
          3'b101: enc_err = (|s1_req_q.imm[31:11]) || (|s1_req_q.imm[9:5]);
          default: enc_err = !i_range_ok;
        endcase
        if (!enc_err) enc_instr = word_i;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    addr_d     = addr_q;
    err_seen_d = err_seen_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_req_d = in_req;
    end

    // S2 payload only changes when a real entry moves in, so it stays put while idle.
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = enc_instr;
        s2_err_d   = enc_err;
      end
    end

    if (out_fire) begin
      addr_d = addr_q + ADDR_W'(4);
      if (s2_err_q) err_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_req_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      err_seen_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_req_q   <= s1_req_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      addr_q     <= addr_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign out_addr  = addr_q;
  assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: encodings, range errors, backpressure, reset, IALU option.
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [31:0] out_addr;
  logic        err_seen;

  localparam logic [31:0] NOP = 32'h0000_0013;

  imm_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .out_addr(out_addr), .err_seen(err_seen)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, last_cyc = 0;
  logic [31:0] q_instr[$], q_addr[$];
  logic        q_err[$];
  int          q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_instr.push_back(out_instr);
      q_err.push_back(out_err);
      q_addr.push_back(out_addr);
      q_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) n_acc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit done = 0;
    in_opcode = op; in_rd = rd; in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) check("push_accept_timeout", 0, 1);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr, input logic err,
                             input logic [31:0] addr);
    int waited = 0;
    while (q_instr.size() == 0 && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (q_instr.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_instr"}, q_instr.pop_front(), instr);
      check({tag, "_err"},   q_err.pop_front(),   err);
      check({tag, "_addr"},  q_addr.pop_front(),  addr);
      last_cyc = q_cyc.pop_front();
    end
  endtask

  task automatic rst_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q_instr.delete(); q_err.delete(); q_addr.delete(); q_cyc.delete();
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, instr;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int c0, base;
    bit bp_done = 0;

    // asynchronous reset state, before any clock edge
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_err",   out_err,   0);
    check("rst_out_addr",  out_addr,  0);
    check("rst_err_seen",  err_seen,  0);
    check("rst_in_ready",  in_ready,  1);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw x5,-4(x2): latency 2
    out_ready = 1'b1;
    push(7'h03, 5'd5, 3'd2, 5'd2, 5'd0, 32'hFFFF_FFFC);
    @(negedge clk);
    check("lw_lat_cyc1_valid", out_valid, 0);
    @(negedge clk);
    check("lw_valid", out_valid, 1);
    check("lw_instr", out_instr, 32'hFFC1_2283);
    check("lw_err",   out_err,   0);
    check("lw_addr",  out_addr,  0);

    // back-to-back stream
    rst_dut();
    push(7'h23, 5'd0, 3'd2, 5'd2, 5'd6, 32'd8);
    push(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    expect_word("sw", 32'h0061_2423, 0, 32'd0);
    c0 = last_cyc;
    expect_word("beq", 32'hFE20_8CE3, 0, 32'd4);
    check("stream_rate", last_cyc - c0, 1);
    check("err_seen_clean", err_seen, 0);

    // first error, then sticky flag
    push(7'h03, 5'd1, 3'd2, 5'd0, 5'd0, 32'h0000_0800);
    expect_word("lw_big", NOP, 1, 32'd8);
    check("err_seen_set", err_seen, 1);

    // table of range boundaries and further errors
    vecs = '{
      '{op:7'h63, f3:3'd0, rd:5'd0, rs1:5'd1, rs2:5'd2, imm:32'd3,          instr:NOP,          err:1'b1},
      '{op:7'h33, f3:3'd0, rd:5'd1, rs1:5'd2, rs2:5'd3, imm:32'd0,          instr:NOP,          err:1'b1},
      '{op:7'h03, f3:3'd2, rd:5'd1, rs1:5'd0, rs2:5'd0, imm:32'h0000_07FF,  instr:32'h7FF0_2083, err:1'b0},
      '{op:7'h03, f3:3'd2, rd:5'd1, rs1:5'd0, rs2:5'd0, imm:32'hFFFF_F800,  instr:32'h8000_2083, err:1'b0},
      '{op:7'h23, f3:3'd2, rd:5'd0, rs1:5'd0, rs2:5'd0, imm:32'hFFFF_F800,  instr:32'h8000_2023, err:1'b0},
      '{op:7'h63, f3:3'd0, rd:5'd0, rs1:5'd0, rs2:5'd0, imm:32'h0000_0FFE,  instr:32'h7E00_0FE3, err:1'b0},
      '{op:7'h63, f3:3'd0, rd:5'd0, rs1:5'd0, rs2:5'd0, imm:32'hFFFF_F000,  instr:32'h8000_0063, err:1'b0},
      '{op:7'h63, f3:3'd0, rd:5'd0, rs1:5'd0, rs2:5'd0, imm:32'h0000_1000,  instr:NOP,          err:1'b1},
      '{op:7'h23, f3:3'd2, rd:5'd0, rs1:5'd0, rs2:5'd0, imm:32'hFFFF_F7FF,  instr:NOP,          err:1'b1}
    };
    foreach (vecs[i]) push(vecs[i].op, vecs[i].rd, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
    foreach (vecs[i]) expect_word($sformatf("vec%0d", i), vecs[i].instr, vecs[i].err, 32'd12 + 32'(i) * 4);
    check("err_seen_sticky", err_seen, 1);

    // backpressure: 3 requests, consumer stalled
    rst_dut();
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        push(7'h03, 5'd1, 3'd2, 5'd0, 5'd0, 32'd0);
        push(7'h03, 5'd2, 3'd2, 5'd0, 5'd0, 32'd0);
        push(7'h03, 5'd3, 3'd2, 5'd0, 5'd0, 32'd0);
        bp_done = 1;
      end
    join_none
    repeat (4) @(negedge clk);
    #1;
    check("bp_accepts", n_acc - base, 2);
    check("bp_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_instr", out_instr, 32'h0000_2083);
      check("bp_hold_addr",  out_addr,  0);
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    expect_word("bp0", 32'h0000_2083, 0, 32'd0);
    expect_word("bp1", 32'h0000_2103, 0, 32'd4);
    expect_word("bp2", 32'h0000_2183, 0, 32'd8);
    check("bp_all_pushed", bp_done, 1);

    // reset with two entries in flight
    out_ready = 1'b0;
    fork
      begin
        push(7'h03, 5'd4, 3'd2, 5'd0, 5'd0, 32'd0);
        push(7'h03, 5'd5, 3'd2, 5'd0, 5'd0, 32'd0);
      end
    join_none
    repeat (3) @(negedge clk);
    check("mid_inflight", out_valid, 1);
    check("mid_addr_before", out_addr, 12);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_addr",  out_addr,  0);
    @(posedge clk);
    #1 reset = 1'b0;
    q_instr.delete(); q_err.delete(); q_addr.delete(); q_cyc.delete();
    out_ready = 1'b1;
    push(7'h23, 5'd0, 3'd2, 5'd2, 5'd6, 32'd8);
    expect_word("post_rst", 32'h0061_2423, 0, 32'd0);
    repeat (2) @(negedge clk);
    check("post_rst_drained", out_valid, 0);

    // I-type ALU: srai x1,x1,3
    push(7'h13, 5'd1, 3'd5, 5'd1, 5'd0, 32'h0000_0403);
`ifdef IMM_ENC_IALU_EN
    expect_word("srai", 32'h4030_D093, 0, 32'd4);
`else
    expect_word("srai", NOP, 1, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
